// File: rtl/uart_receive_if.sv
// uart_receive_if: serial line in, received word and status strobes out.
interface uart_receive_if #(parameter int DATA_WIDTH = 8);
  logic rx_wire_in;
  logic [DATA_WIDTH-1:0] data_byte_out;
  logic new_data_out;
  logic framing_error_out;
  modport master(input rx_wire_in, output data_byte_out, new_data_out, framing_error_out);
  modport slave(output rx_wire_in, input data_byte_out, new_data_out, framing_error_out);
endinterface

// File: rtl/uart_receive.sv
// uart_receive: 8N1-style UART receiver, mid-bit sampling with a baud counter.
// Define UART_RX_FRAMING_CHECK_EN to flag low stop bits and wait out breaks.
module uart_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_WIDTH = 8
) (
  input logic clk_in,
  input logic rst_in,
  uart_receive_if.master bus
);
  localparam int P = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int H = P / 2;
  localparam int CW = $clog2(P);
  localparam int BW = $clog2(DATA_WIDTH);
`ifdef UART_RX_FRAMING_CHECK_EN
  typedef enum logic [1:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic rx_meta, rx_s;
  logic [CW-1:0] count;
  logic [BW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] shift, data;
  logic new_data, framing_error;
  assign bus.data_byte_out = data;
  assign bus.new_data_out = new_data;
`ifdef UART_RX_FRAMING_CHECK_EN
  assign bus.framing_error_out = framing_error;
`else
  assign bus.framing_error_out = 1'b0;
`endif
  // synchronizer resets high so reset release never looks like a start bit
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      count <= '0;
      bit_idx <= '0;
      shift <= '0;
      data <= '0;
      new_data <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_meta <= bus.rx_wire_in;
      rx_s <= rx_meta;
      new_data <= 1'b0;
      framing_error <= 1'b0;
      count <= count + 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          count <= '0;
        end
        START: if (count == CW'(H - 1)) begin
          state <= rx_s ? IDLE : DATA;
          count <= '0;
          bit_idx <= '0;
        end
        DATA: if (count == CW'(P - 1)) begin
          shift <= {rx_s, shift[DATA_WIDTH-1:1]};
          count <= '0;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BW'(DATA_WIDTH - 1)) state <= STOP;
        end
        STOP: if (count == CW'(P - 1)) begin
          count <= '0;
`ifdef UART_RX_FRAMING_CHECK_EN
          if (rx_s) begin
            data <= shift;
            new_data <= 1'b1;
            state <= IDLE;
          end else begin
            framing_error <= 1'b1;
            state <= WAIT_HIGH;
          end
`else
          data <= shift;
          new_data <= 1'b1;
          state <= IDLE;
`endif
        end
`ifdef UART_RX_FRAMING_CHECK_EN
        WAIT_HIGH: if (rx_s) begin
          state <= IDLE;
          count <= '0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: scoreboard bench for uart_receive at P=8, H=4.
module tb_uart_receive;
  localparam int P = 8;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int passed = 0, total = 0;
  int cyc = 0, t0 = 0, last_nd_edge = 0, prev_nd_edge = 0;
  int nd_count = 0, fe_count = 0, viol = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] exp_q[$];
  uart_receive_if #(.DATA_WIDTH(8)) bus ();
  uart_receive #(.INPUT_CLOCK_FREQ(100_000_000), .BAUD_RATE(12_500_000), .DATA_WIDTH(8))
    dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // strobe edge is the first clock edge that sees the strobe high
  always @(negedge clk_in) begin
    if (bus.new_data_out && bus.framing_error_out) viol++;
    if (prev_strobe && (bus.new_data_out || bus.framing_error_out)) viol++;
    prev_strobe = bus.new_data_out || bus.framing_error_out;
    if (bus.framing_error_out) fe_count++;
    if (bus.new_data_out) begin
      nd_count++;
      prev_nd_edge = last_nd_edge;
      last_nd_edge = cyc + 1;
      check("word_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("word", 32'(bus.data_byte_out), 32'(exp_q.pop_front()));
    end
  end
  task automatic send_bit(input logic b);
    bus.rx_wire_in = b;
    repeat (P) @(posedge clk_in);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push);
    t0 = cyc + 1;
    if (push) exp_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask
  task automatic idle(input int n);
    bus.rx_wire_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  initial begin
    int nd0, fe0, exp_fe;
    bus.rx_wire_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_data", 32'(bus.data_byte_out), 0);
    check("rst_new", 32'(bus.new_data_out), 0);
    check("rst_fe", 32'(bus.framing_error_out), 0);
    rst_in = 1'b0;
    idle(5);
    send_frame(8'hA5, 1'b1, 1);
    idle(20);
    check("a5_count", 32'(nd_count), 1);
    check("a5_timing", 32'(last_nd_edge >= t0 + 78 && last_nd_edge <= t0 + 80), 1);
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    idle(20);
    check("b2b_count", 32'(nd_count), 3);
    check("b2b_spacing", 32'(last_nd_edge - prev_nd_edge), 80);
    nd0 = nd_count;
    fe0 = fe_count;
    bus.rx_wire_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    idle(30);
    check("glitch_new", 32'(nd_count), 32'(nd0));
    check("glitch_fe", 32'(fe_count), 32'(fe0));
    check("glitch_data", 32'(bus.data_byte_out), 32'hFF);
`ifdef UART_RX_FRAMING_CHECK_EN
    send_frame(8'h3C, 1'b0, 0);
    bus.rx_wire_in = 1'b0;
    repeat (32) @(posedge clk_in);
    #1;
    idle(20);
    check("fe_count", 32'(fe_count), 32'(fe0 + 1));
    check("fe_no_new", 32'(nd_count), 32'(nd0));
    check("fe_data_held", 32'(bus.data_byte_out), 32'hFF);
    exp_fe = 1;
`else
    send_frame(8'h3C, 1'b0, 1);
    idle(20);
    check("nofe_count", 32'(fe_count), 32'(fe0));
    check("nofe_new", 32'(nd_count), 32'(nd0 + 1));
    exp_fe = 0;
`endif
    send_frame(8'h11, 1'b1, 1);
    idle(20);
    check("after_err_data", 32'(bus.data_byte_out), 32'h11);
    nd0 = nd_count;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    bus.rx_wire_in = 1'b1;
    repeat (P / 2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    check("midrst_data", 32'(bus.data_byte_out), 0);
    check("midrst_new", 32'(bus.new_data_out), 0);
    check("midrst_fe", 32'(bus.framing_error_out), 0);
    repeat (P / 2) @(posedge clk_in);
    #1;
    for (int i = 5; i < 8; i++) send_bit(1'(8'h5A >> i));
    send_bit(1'b1);
    idle(10);
    rst_in = 1'b0;
    idle(10);
    check("midrst_nothing", 32'(nd_count), 32'(nd0));
    send_frame(8'hC3, 1'b1, 1);
    idle(20);
    check("post_rst_data", 32'(bus.data_byte_out), 32'hC3);
    nd0 = nd_count;
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1);
    idle(30);
    check("loop_count", 32'(nd_count), 32'(nd0 + 256));
    check("queue_empty", 32'(exp_q.size()), 0);
    check("fe_total", 32'(fe_count), 32'(exp_fe));
    check("strobe_rules", 32'(viol), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
